// File: rtl/oddr_pattern_gen.sv
// oddr_pattern_gen
// Multi-channel DDR pattern source for external ODDR primitives and tristate
// buffers. A rising edge on enable launches one framed sequence:
// LEAD (oe on, data 0) -> RUN (pattern data) -> TAIL (oe on, data 0) -> IDLE.
// The first IDLE cycle after a sequence carries a one-cycle done pulse.
// All outputs are registered. They follow the state register by one cycle,
// so the frame that a state produces appears on the edge after that state
// is entered.
module oddr_pattern_gen #(
    parameter int NUM_CH   = 4,
    parameter int PAT_W    = 16,
    parameter int CNT_W    = 16,
    parameter int LEAD_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [PAT_W-1:0]  pattern,
    input  logic [CNT_W-1:0]  burst_len,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [NUM_CH-1:0] d_rise,
    output logic [NUM_CH-1:0] d_fall,
    output logic [NUM_CH-1:0] oe,
    output logic              busy,
    output logic              done
);

    localparam int LEAD_W = (LEAD_CYC > 1) ? $clog2(LEAD_CYC) : 1;
    localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(LEAD_CYC - 1);

    localparam logic [1:0] MODE_CLKFWD  = 2'd0;
    localparam logic [1:0] MODE_PATTERN = 2'd1;
    localparam logic [1:0] MODE_PRBS7   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LEAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_TAIL = 2'd3
    } state_t;

    state_t             state;
    logic               enable_q;
    logic [1:0]         mode_q;
    logic [PAT_W-1:0]   pat_q;
    logic [CNT_W-1:0]   burst_q;
    logic [NUM_CH-1:0]  mask_q;
    logic [6:0]         lfsr;
    logic [CNT_W-1:0]   run_cnt;
    logic [LEAD_W-1:0]  lead_cnt;
    logic               done_pend;

    logic               nb1;
    logic               nb2;
    logic [6:0]         lfsr_1;
    logic [6:0]         lfsr_2;

    // Two x^7+x^6+1 steps per cycle: the first new bit feeds rise, the second fall.
    always_comb begin
        nb1    = lfsr[6] ^ lfsr[5];
        lfsr_1 = {lfsr[5:0], nb1};
        nb2    = lfsr_1[6] ^ lfsr_1[5];
        lfsr_2 = {lfsr_1[5:0], nb2};
    end

    // Sequencer FSM with registered channel outputs, busy and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            enable_q  <= 1'b1;     // a fresh rising edge is needed after reset
            mode_q    <= '0;
            pat_q     <= '0;
            burst_q   <= '0;
            mask_q    <= '0;
            lfsr      <= 7'h7F;
            run_cnt   <= '0;
            lead_cnt  <= '0;
            done_pend <= 1'b0;
            d_rise    <= '0;
            d_fall    <= '0;
            oe        <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            enable_q <= enable;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    d_rise    <= '0;
                    d_fall    <= '0;
                    oe        <= '0;
                    busy      <= 1'b0;
                    done      <= done_pend;
                    done_pend <= 1'b0;
                    if (enable && !enable_q) begin
                        mode_q   <= mode;
                        pat_q    <= pattern;
                        burst_q  <= burst_len;
                        mask_q   <= ch_mask;
                        lfsr     <= 7'h7F;
                        run_cnt  <= '0;
                        lead_cnt <= '0;
                        state    <= (LEAD_CYC == 0) ? ST_RUN : ST_LEAD;
                    end
                end

                ST_LEAD: begin
                    d_rise <= '0;
                    d_fall <= '0;
                    oe     <= mask_q;
                    busy   <= 1'b1;
                    if (!enable) begin
                        // Abort: this edge already emits the tail frame.
                        done_pend <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (lead_cnt == LEAD_LAST) begin
                        state <= ST_RUN;
                    end else begin
                        lead_cnt <= lead_cnt + 1'b1;
                    end
                end

                ST_RUN: begin
                    oe   <= mask_q;
                    busy <= 1'b1;
                    if (!enable) begin
                        // Abort: the tail frame replaces this cycle's data.
                        d_rise    <= '0;
                        d_fall    <= '0;
                        done_pend <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        case (mode_q)
                            MODE_CLKFWD: begin
                                d_rise <= mask_q;
                                d_fall <= '0;
                            end
                            MODE_PATTERN: begin
                                d_rise <= {NUM_CH{pat_q[PAT_W-1]}} & mask_q;
                                d_fall <= {NUM_CH{pat_q[PAT_W-2]}} & mask_q;
                                // Rotate left by one DDR pair; written with shifts
                                // so PAT_W = 2 needs no zero-width slice.
                                pat_q  <= (pat_q << 2) | (pat_q >> (PAT_W - 2));
                            end
                            MODE_PRBS7: begin
                                d_rise <= {NUM_CH{nb1}} & mask_q;
                                d_fall <= {NUM_CH{nb2}} & mask_q;
                                lfsr   <= lfsr_2;
                            end
                            default: begin
                                d_rise <= mask_q;
                                d_fall <= mask_q;
                            end
                        endcase
                        // Continuous bursts never count, so they cannot wrap into TAIL.
                        if (burst_q != '0) begin
                            if (run_cnt == burst_q - 1'b1) begin
                                state <= ST_TAIL;
                            end else begin
                                run_cnt <= run_cnt + 1'b1;
                            end
                        end
                    end
                end

                ST_TAIL: begin
                    d_rise    <= '0;
                    d_fall    <= '0;
                    oe        <= mask_q;
                    busy      <= 1'b1;
                    done_pend <= 1'b1;
                    state     <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/oddr_pattern_gen.md
Name: oddr_pattern_gen

Overview:
- Multi-channel, parametrised successor to the single-output ODDR test driver.
- Generates per-channel rising/falling-edge data and output-enable for external ODDR primitives and tristate buffers on FPGA inout pins.
- Supports selectable patterns (clock-forward, rotating user pattern, PRBS7, static high), finite or continuous bursts, lead-in/tail framing, per-channel masking and a done pulse.
- Control comes from a VIO or a sequencer; all logic runs on the 100 MHz fabric clock.

Parameters:
- NUM_CH, 4, number of output channels.
- PAT_W, 16, user pattern width in DDR bits; must be even and >= 2.
- CNT_W, 16, width of burst_len.
- LEAD_CYC, 2, lead-in cycles (oe active, data 0) before pattern; 0 skips LEAD.

Ports:
- clk  in  1  fabric clock.
- rst_n  in  1  async active-low reset.
- enable  in  1  run request; a rising edge starts a sequence, low aborts it.
- mode  in  2  0=CLKFWD, 1=PATTERN, 2=PRBS7, 3=STATIC_HI.
- pattern  in  PAT_W  user pattern; MSB is transmitted first.
- burst_len  in  CNT_W  RUN cycles per burst; 0 = continuous.
- ch_mask  in  NUM_CH  1 = channel participates.
- d_rise  out  NUM_CH  ODDR D1, rising-edge data.
- d_fall  out  NUM_CH  ODDR D2, falling-edge data.
- oe  out  NUM_CH  tristate enable, 1 = drive.
- busy  out  1  high in LEAD/RUN/TAIL.
- done  out  1  one-cycle pulse on return to IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - d_rise, d_fall, oe, busy, done = 0.
  - enable_q = 1, so a start requires a fresh rising edge after reset.
  - lfsr = 7'h7F; counters = 0.
- All outputs are registered.
- Start: in IDLE, enable=1 && enable_q=0 at edge N.
  - Latch mode, pattern, burst_len and ch_mask.
  - Load pat_q = pattern and lfsr = 7'h7F.
  - Go to LEAD, or to RUN if LEAD_CYC=0.
- Outside IDLE, the enable edge is ignored. Input changes after the start edge have no effect.
- LEAD:
  - Lasts exactly LEAD_CYC cycles, outputs N+1..N+LEAD_CYC.
  - oe = mask_q, d_rise = d_fall = 0.
- RUN:
  - First data appears on outputs in cycle N+LEAD_CYC+1.
  - oe = mask_q.
  - Per cycle, by mode:
    - CLKFWD: rise = 1, fall = 0.
    - PATTERN: rise = pat_q[PAT_W-1], fall = pat_q[PAT_W-2]; pat_q rotates left by 2. Period = PAT_W/2 cycles.
    - PRBS7 (x^7+x^6+1): each step, nb = lfsr[6]^lfsr[5], lfsr = {lfsr[5:0], nb}. Two steps per cycle; the first nb drives rise, the second drives fall.
    - STATIC_HI: rise = fall = 1.
  - All unmasked channels carry identical data. Masked channels have d_rise = d_fall = oe = 0 in every state.
  - Burst: exactly burst_len RUN cycles, then TAIL. burst_len = 0 runs until abort; the counter does not wrap into termination.
- TAIL: one cycle, oe = mask_q, data 0.
- IDLE after TAIL: oe = 0 and data 0. done = 1 for exactly the first IDLE cycle.
- Abort: enable = 0 sampled in LEAD or RUN moves to TAIL on the next cycle. The normal TAIL, done sequence follows, so done pulses for both completion and abort.
- Re-arm: enable held high after done does not restart. A low-then-high transition is required.
- Enable toggling during TAIL is ignored.
- Reset mid-operation: immediate async return to reset values, with no TAIL or done.
- busy = 1 exactly while the state is LEAD, RUN or TAIL.

Test Plan:
- Reset released with enable=1 -> no start, all outputs 0. Drop enable, then raise it at edge N -> oe = mask from N+1, first CLKFWD data at N+3 (LEAD_CYC=2).
- mode=1, pattern=16'hA5C3, burst_len=8, ch_mask=4'b0101 -> ch0/ch2 (rise,fall) per cycle = 10,10,01,01,11,00,00,11. ch1/ch3 stay 0 with oe=0. TAIL follows, then done one-cycle pulse and busy falls with done.
- mode=2, burst_len=4 -> (rise,fall) = (0,0),(0,0),(0,0),(1,0).
- mode=0, burst_len=0, enable held 1000 cycles -> continuous 1/0, no done. Enable low at RUN cycle k -> TAIL at k+1, done at k+2.
- enable held high through done -> no second burst. Low-then-high -> second burst identical to the first (lfsr reseeded to 7'h7F).
- rst_n asserted mid-RUN -> outputs 0 asynchronously, done stays 0, state IDLE after release.
